sprite_cmd_scheduler: RTL and testbench
=======================================

SPRITE_CMD_SCHEDULER -- requirements
Module: sprite_cmd_scheduler

Interface
REQ-001 Parameter HALF_PERIOD, default 4, meaning clk cycles per spr_clk half-period; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a command pending.
REQ-005 req0_command  input  4  requester 0 sprite command code.
REQ-006 req0_data  input  10  requester 0 sprite command argument.
REQ-007 req0_ready  output  1  requester 0 command accepted when req0_valid and req0_ready are both high on a clk edge.
REQ-008 req1_valid, req1_command[3:0], req1_data[9:0], req1_ready  same directions, widths and meaning as REQ-004..007 for requester 1.
REQ-009 spr_clk  output  1  serial link clock to the sprite receiver.
REQ-010 spr_cmd  output  1  serial link strobe; high during a spr_clk rising edge commits the shifted command.
REQ-011 spr_ser  output  1  serial link data bit.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be SYNC, IDLE, SHIFT, STROBE; reset enters SYNC.
REQ-014 Each link bit SHALL occupy 2*HALF_PERIOD clk cycles: low phase first (spr_clk=0, HALF_PERIOD cycles), then high phase (spr_clk=1, HALF_PERIOD cycles).
REQ-015 spr_cmd and spr_ser SHALL change only on the first cycle of a low phase and SHALL stay stable through the following high phase.
REQ-016 SYNC SHALL emit exactly one bit with spr_cmd=1, spr_ser=0, then go to IDLE; purpose: reset receiver command-length counter after any abort.
REQ-017 In IDLE: spr_clk=0, spr_cmd=0, spr_ser=0.
REQ-018 reqN_ready SHALL be high only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-019 Grant rule in IDLE: if only one valid, grant it; if both valid, grant the requester selected by round-robin pointer rr.
REQ-020 rr SHALL be set to the non-granted requester index on every accept; reset value rr=0.
REQ-021 Ready SHALL be combinational from valid and state (same-cycle grant); accept cycle loads 14-bit shift register {command, data} and enters SHIFT on the next cycle.
REQ-022 SHIFT SHALL emit 14 bits MSB first (command[3] .. command[0], data[9] .. data[0]) with spr_cmd=0, counted by a 4-bit bit counter 0..13.
REQ-023 After bit 13, STROBE SHALL emit one bit with spr_cmd=1, spr_ser=0, then return to IDLE.
REQ-024 Frame length SHALL be exactly 30*HALF_PERIOD clk cycles from the cycle after accept to first IDLE cycle; a new accept may occur in that first IDLE cycle.
REQ-025 Half-period counter SHALL count 0..HALF_PERIOD-1 and wrap; bit counter SHALL not wrap past 13.
REQ-026 reqN_command/reqN_data changes after accept SHALL not affect the frame in flight.
REQ-027 valid deasserted before grant SHALL leave no side effect; rr SHALL only change on accept.

Reset
REQ-028 Asserting reset at any time, including mid-frame, SHALL immediately force spr_clk=0, spr_cmd=0, spr_ser=0, req0_ready=0, req1_ready=0, busy=1, rr=0, all counters 0, state SYNC.
REQ-029 The aborted frame SHALL not resume; on release the block SHALL emit the SYNC bit before any accept.
REQ-030 Frame in progress SHALL not be aborted by requester valid changes.

Verification
REQ-031 Reset release, no requests, HALF_PERIOD=4 -> one spr_clk pulse with spr_cmd=1 (8 cycles), then busy=0, all link outputs 0.
REQ-032 req0 command=4'hA data=10'h2C5 -> 14 spr_clk rising edges sampling spr_ser 1,0,1,0,1,0,1,1,0,0,0,1,0,1, spr_cmd=0, then one rising edge with spr_cmd=1; total 120 cycles; a model receiver shows write with command 4'hA data 10'h2C5.
REQ-033 Both valid continuously, 4 frames -> grants 0,1,0,1; req0_data and req1_data each committed twice, no frame gap beyond the single IDLE accept cycle.
REQ-034 Reset asserted at bit 6 of a frame -> outputs zero same cycle; after release SYNC bit, next frame command=4'h3 data=10'h001 decoded correctly by model receiver.
REQ-035 req1 only valid after rr=1 reset-state check, and req0 valid deasserted mid-IDLE -> req1 granted immediately, rr becomes 0.
REQ-036 HALF_PERIOD=2 -> frame length 60 cycles, spr_ser/spr_cmd never change while spr_clk=1.

Source files
------------

// File: rtl/sprite_cmd_if.sv
// sprite_cmd_if: bundles the two requester handshakes and the serial sprite link.
//   reqN_valid/command/data : requester -> scheduler command offer
//   reqN_ready              : scheduler -> requester, accept when valid & ready
//   spr_clk/spr_cmd/spr_ser : serial link to the sprite receiver
//   busy                    : scheduler not in IDLE
// master = requester/link side, slave = scheduler.
interface sprite_cmd_if;
  logic       req0_valid;
  logic [3:0] req0_command;
  logic [9:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_command;
  logic [9:0] req1_data;
  logic       req1_ready;
  logic       spr_clk;
  logic       spr_cmd;
  logic       spr_ser;
  logic       busy;

  modport master (
    output req0_valid, req0_command, req0_data,
    output req1_valid, req1_command, req1_data,
    input  req0_ready, req1_ready,
    input  spr_clk, spr_cmd, spr_ser, busy
  );

  modport slave (
    input  req0_valid, req0_command, req0_data,
    input  req1_valid, req1_command, req1_data,
    output req0_ready, req1_ready,
    output spr_clk, spr_cmd, spr_ser, busy
  );
endinterface

// File: rtl/sprite_cmd_scheduler.sv
// sprite_cmd_scheduler: arbitrates two command requesters (round robin) and
// serialises the granted {command[3:0], data[9:0]} onto a 3-wire sprite link.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : sprite_cmd_if.slave (requester handshakes + spr_clk/spr_cmd/spr_ser + busy)
// Each link bit is HALF_PERIOD cycles low then HALF_PERIOD cycles high.
// Frame = 14 data bits + 1 strobe bit. After reset a lone strobe bit (SYNC)
// realigns the receiver's bit counter.
module sprite_cmd_scheduler #(
  parameter int HALF_PERIOD = 4
) (
  input  logic         clk,
  input  logic         reset,
  sprite_cmd_if.slave  bus
);
  typedef enum logic [1:0] {SYNC, IDLE, SHIFT, STROBE} state_t;

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  state_t      state, state_nxt;
  logic        run;      // low during the reset cycle so link outputs stay 0 until release
  logic [7:0]  hp_cnt;
  logic        phase;    // 0 = low half, 1 = high half of the current bit
  logic [3:0]  bit_cnt;
  logic [13:0] sr;
  logic        rr;

  logic idle, ticking, hp_end, bit_end;
  logic g0, g1, accept;

  assign idle    = (state == IDLE);
  assign ticking = (state == SHIFT) || (state == STROBE) || ((state == SYNC) && run);
  assign hp_end  = (hp_cnt == HP_LAST);
  assign bit_end = hp_end && phase;

  // Same-cycle grant; rr only breaks ties.
  assign g0 = bus.req0_valid && (!bus.req1_valid || !rr);
  assign g1 = bus.req1_valid && (!bus.req0_valid ||  rr);
  assign bus.req0_ready = idle && g0;
  assign bus.req1_ready = idle && g1;
  assign accept         = bus.req0_ready || bus.req1_ready;

  // Link outputs are functions of state only, so they move solely at bit
  // boundaries (start of a low phase).
  assign bus.spr_clk = ticking && phase;
  assign bus.spr_cmd = ((state == SYNC) && run) || (state == STROBE);
  assign bus.spr_ser = (state == SHIFT) && sr[13];
  assign bus.busy    = !idle;

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (run && bit_end) state_nxt = IDLE;
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (bit_end && bit_cnt == 4'd13) state_nxt = STROBE;
      STROBE:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SYNC;
      run     <= 1'b0;
      hp_cnt  <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      sr      <= '0;
      rr      <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      if (ticking) begin
        if (hp_end) begin
          hp_cnt <= '0;
          phase  <= !phase;
        end else begin
          hp_cnt <= hp_cnt + 8'd1;
        end
        if (bit_end && state == SHIFT) begin
          sr      <= {sr[12:0], 1'b0};
          bit_cnt <= (bit_cnt == 4'd13) ? 4'd0 : bit_cnt + 4'd1;
        end
      end else begin
        hp_cnt  <= '0;
        phase   <= 1'b0;
        bit_cnt <= '0;
      end
      // Command is captured at accept; later requester changes cannot reach the frame.
      if (accept) begin
        sr <= bus.req0_ready ? {bus.req0_command, bus.req0_data}
                             : {bus.req1_command, bus.req1_data};
        rr <= bus.req0_ready;  // point at the requester that lost
      end
    end
  end
endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
module tb_sprite_cmd_scheduler;
  localparam int HP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_cmd_if bus();
  sprite_cmd_if bus2();

  sprite_cmd_scheduler #(.HALF_PERIOD(HP)) dut (.clk(clk), .reset(rst), .bus(bus));
  sprite_cmd_scheduler #(.HALF_PERIOD(2))  dut2 (.clk(clk), .reset(rst2), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event, required event within bound (t=%0t)", name, $time);
  endtask

  // ---------------- reference model + link receiver (main DUT) ----------------
  logic [13:0] exp_q[$];
  bit          rr_m = 0;
  bit          in_frame = 0;
  int          f_start = 0;
  bit          expect_sync = 1;
  bit          prev_clk = 0, prev_cmd = 0, prev_ser = 0;
  int          hi_len = 0;
  int          rx_cnt = 0;
  logic [13:0] rx_sh = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      rr_m = 0; in_frame = 0; expect_sync = 1;
      prev_clk = 0; hi_len = 0;
    end else begin
      // receiver: act on spr_clk rising edges, check high-phase stability
      if (bus.spr_clk) begin
        if (!prev_clk) begin
          hi_len = 1;
          if (expect_sync) begin
            chk("sync_cmd", bus.spr_cmd, 1);
            chk("sync_ser", bus.spr_ser, 0);
            expect_sync = 0;
            rx_cnt = 0;
          end else if (bus.spr_cmd) begin
            chk("strobe_ser", bus.spr_ser, 0);
            if (rx_cnt != 14) chk("strobe_bitcount", rx_cnt, 14);
            else if (exp_q.size() == 0) fail("write_unexpected");
            else chk("write", rx_sh, exp_q.pop_front());
            rx_cnt = 0;
          end else begin
            rx_sh = {rx_sh[12:0], bus.spr_ser};
            rx_cnt++;
          end
        end else begin
          hi_len++;
          chk("stable_hi", {bus.spr_cmd, bus.spr_ser}, {prev_cmd, prev_ser});
        end
      end else if (prev_clk) begin
        chk("hi_len", hi_len, HP);
      end
      prev_clk = bus.spr_clk; prev_cmd = bus.spr_cmd; prev_ser = bus.spr_ser;

      if (in_frame && !bus.busy) begin
        chk("frame_len", cyc - f_start, 30 * HP);
        in_frame = 0;
      end

      // grant rule: single valid wins, otherwise rr decides
      if (!bus.busy) begin
        bit v0, v1, e0, e1;
        v0 = bus.req0_valid; v1 = bus.req1_valid;
        e0 = v0 && (!v1 || rr_m == 0);
        e1 = v1 && (!v0 || rr_m == 1);
        chk("ready", {bus.req1_ready, bus.req0_ready}, {e1, e0});
        if (e0) begin
          exp_q.push_back({bus.req0_command, bus.req0_data});
          rr_m = 1; in_frame = 1; f_start = cyc + 1;
        end else if (e1) begin
          exp_q.push_back({bus.req1_command, bus.req1_data});
          rr_m = 0; in_frame = 1; f_start = cyc + 1;
        end
      end else begin
        chk("ready_busy", {bus.req1_ready, bus.req0_ready}, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < maxc) begin @(negedge clk); n++; end
    if (bus.busy) fail("idle_timeout");
  endtask

  task automatic send(input bit which, input logic [3:0] c, input logic [9:0] d);
    int n = 0;
    bit hs = 0;
    @(posedge clk); #1;
    if (which) begin bus.req1_valid = 1; bus.req1_command = c; bus.req1_data = d; end
    else       begin bus.req0_valid = 1; bus.req0_command = c; bus.req0_data = d; end
    while (!hs && n < 400) begin
      @(negedge clk);
      hs = which ? bus.req1_ready : bus.req0_ready;
      n++;
    end
    if (!hs) fail("accept_timeout");
    @(posedge clk); #1;
    if (which) bus.req1_valid = 0; else bus.req0_valid = 0;
  endtask

  // ---------------- HALF_PERIOD=2 instance ----------------
  bit          dut2_done = 0;
  bit          prev2 = 0, pcmd2 = 0, pser2 = 0;
  int          cnt2 = 0;
  logic [13:0] sh2 = '0;

  always @(negedge clk) begin
    if (!rst2) begin
      if (bus2.spr_clk) begin
        if (prev2) chk("hp2_stable_hi", {bus2.spr_cmd, bus2.spr_ser}, {pcmd2, pser2});
        else if (bus2.spr_cmd) begin
          if (cnt2 == 14) chk("hp2_write", sh2, {4'h5, 10'h0AA});
          cnt2 = 0;
        end else begin
          sh2 = {sh2[12:0], bus2.spr_ser};
          cnt2++;
        end
      end
      prev2 = bus2.spr_clk; pcmd2 = bus2.spr_cmd; pser2 = bus2.spr_ser;
    end
  end

  initial begin
    int n, start;
    bit hs;
    bus2.req0_valid = 0; bus2.req0_command = '0; bus2.req0_data = '0;
    bus2.req1_valid = 0; bus2.req1_command = '0; bus2.req1_data = '0;
    repeat (3) @(posedge clk);
    #1 rst2 = 0;
    n = 0;
    @(negedge clk);
    while (bus2.busy && n < 100) begin @(negedge clk); n++; end
    if (bus2.busy) fail("hp2_sync_timeout");
    @(posedge clk); #1;
    bus2.req0_valid = 1; bus2.req0_command = 4'h5; bus2.req0_data = 10'h0AA;
    n = 0; hs = 0;
    while (!hs && n < 50) begin @(negedge clk); hs = bus2.req0_ready; n++; end
    if (!hs) fail("hp2_accept_timeout");
    start = cyc + 1;
    @(posedge clk); #1 bus2.req0_valid = 0;
    n = 0;
    @(negedge clk);
    while (bus2.busy && n < 200) begin @(negedge clk); n++; end
    chk("hp2_frame_len", cyc - start, 60);
    dut2_done = 1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int ncmd, nclk, n, acc;
    bus.req0_valid = 1; bus.req0_command = '0; bus.req0_data = '0;
    bus.req1_valid = 1; bus.req1_command = '0; bus.req1_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_link", {bus.spr_clk, bus.spr_cmd, bus.spr_ser}, 0);
    chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("rst_busy", bus.busy, 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(posedge clk); #1 rst = 0;

    // SYNC bit: one spr_clk pulse with spr_cmd high for the whole bit
    ncmd = 0; nclk = 0; n = 0;
    @(negedge clk);
    while (bus.busy && n < 60) begin
      ncmd += int'(bus.spr_cmd); nclk += int'(bus.spr_clk);
      @(negedge clk); n++;
    end
    chk("sync_cmd_cycles", ncmd, 2 * HP);
    chk("sync_clk_cycles", nclk, HP);
    chk("idle_link", {bus.busy, bus.spr_clk, bus.spr_cmd, bus.spr_ser}, 0);

    // directed frame, then req0 pulse that is withdrawn before grant
    send(0, 4'hA, 10'h2C5);
    repeat (20) @(posedge clk);
    #1 bus.req0_valid = 1;
    repeat (10) @(posedge clk);
    #1 bus.req0_valid = 0;
    wait_idle(200);
    send(1, 4'h6, 10'h155);
    wait_idle(200);

    // both valid continuously for 4 frames
    @(posedge clk); #1;
    bus.req0_valid = 1; bus.req0_command = 4'h1; bus.req0_data = 10'h111;
    bus.req1_valid = 1; bus.req1_command = 4'h2; bus.req1_data = 10'h222;
    acc = 0; n = 0;
    while (acc < 4 && n < 800) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) acc++;
      n++;
    end
    if (acc < 4) fail("rr_accept_timeout");
    @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    wait_idle(200);

    // randomized traffic
    repeat (1500) begin
      @(posedge clk); #1;
      bus.req0_valid = ($urandom_range(0, 5) == 0);
      bus.req1_valid = ($urandom_range(0, 5) == 0);
      bus.req0_command = 4'($urandom); bus.req0_data = 10'($urandom);
      bus.req1_command = 4'($urandom); bus.req1_data = 10'($urandom);
    end
    @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    wait_idle(200);

    // reset during bit 6 of a frame
    send(0, 4'h7, 10'h3FF);
    repeat (12 * HP + 1) @(posedge clk);
    #1 rst = 1; bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    chk("abort_link", {bus.spr_clk, bus.spr_cmd, bus.spr_ser}, 0);
    chk("abort_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("abort_busy", bus.busy, 1);
    repeat (3) @(posedge clk);
    #1 rst = 0; bus.req0_valid = 0; bus.req1_valid = 0;
    wait_idle(60);
    send(0, 4'h3, 10'h001);
    wait_idle(200);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    n = 0;
    while (!dut2_done && n < 1000) begin @(posedge clk); n++; end
    if (!dut2_done) fail("hp2_done_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
